echo_serializer: RTL and testbench

Downstream stage of the ping-pong echo FIFO pair. Pulls one 704-bit echo item (tag word, length word, 20 payload words) from the FIFO's first/deq interface, then emits it as a stream of 32-bit words on an enq-style output. It sends only the header plus the number of payload words given by the length field, and flags the final word. Back-to-back items stream with no idle cycle between them.

---
 rtl/echo_serializer.sv | 120 ++++++++++++
 tb/tb_echo_serializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_serializer.sv
// Serializes one 704-bit echo item (tag, length, 20 payload words) into 32-bit words,
// sending only header + min(N, DATA_WORDS) payload words, with no bubble between items.
module echo_serializer #(
   parameter int WIDTH      = 32,
   parameter int DATA_WORDS = 20
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [WIDTH*(DATA_WORDS+2)-1:0]    in_first,
   input  logic                               in_first_rdy,
   input  logic                               in_deq_rdy,
   output logic                               in_deq_ena,
   output logic                               out_enq_ena,
   output logic [WIDTH-1:0]                   out_enq_v,
   output logic                               out_enq_last,
   input  logic                               out_enq_rdy
);

   localparam int ITEM_WORDS = DATA_WORDS + 2;
   localparam int ITEM_W     = WIDTH * ITEM_WORDS;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t              r_state;
   state_t              r_state_next;
   logic [ITEM_W-1:0]   r_item;
   logic [ITEM_W-1:0]   r_item_next;
   logic [4:0]          r_cnt;
   logic [4:0]          r_cnt_next;
   logic [4:0]          r_limit;
   logic [4:0]          r_limit_next;
   logic                r_ena;
   logic                r_ena_next;
   logic [WIDTH-1:0]    r_v;
   logic [WIDTH-1:0]    r_v_next;
   logic                r_last;
   logic                r_last_next;

   logic [WIDTH-1:0]    w_words [ITEM_WORDS];
   logic [WIDTH-1:0]    w_len;
   logic [4:0]          w_new_limit;
   logic [4:0]          w_cnt_inc;
   logic                w_xfer;
   logic                w_load;

   genvar gi;
   generate
      for (gi = 0; gi < ITEM_WORDS; gi++) begin : g_words
         assign w_words[gi] = r_item[gi*WIDTH +: WIDTH];
      end
   endgenerate

   assign w_len       = in_first[2*WIDTH-1:WIDTH];
   // Clamp on the full 32-bit length so huge values (e.g. all ones) still send every slot.
   assign w_new_limit = (w_len >= WIDTH'(DATA_WORDS)) ? 5'(ITEM_WORDS) : (w_len[4:0] + 5'd2);
   assign w_cnt_inc   = r_cnt + 5'd1;
   assign w_xfer      = r_ena && out_enq_rdy;
   assign w_load      = in_first_rdy && in_deq_rdy &&
                        ((r_state == S_IDLE) || (w_xfer && r_last));

   assign in_deq_ena   = w_load && !RST;
   assign out_enq_ena  = r_ena;
   assign out_enq_v    = r_v;
   assign out_enq_last = r_last;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_item  <= '0;
         r_cnt   <= '0;
         r_limit <= '0;
         r_ena   <= 1'b0;
         r_v     <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= r_state_next;
         r_item  <= r_item_next;
         r_cnt   <= r_cnt_next;
         r_limit <= r_limit_next;
         r_ena   <= r_ena_next;
         r_v     <= r_v_next;
         r_last  <= r_last_next;
      end
   end

   always_comb begin
      r_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_load) r_state_next = S_SEND;
         S_SEND: if (w_xfer && r_last && !w_load) r_state_next = S_IDLE;
         default: r_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      r_item_next  = r_item;
      r_cnt_next   = r_cnt;
      r_limit_next = r_limit;
      r_ena_next   = r_ena;
      r_v_next     = r_v;
      r_last_next  = r_last;
      if (w_load) begin
         r_item_next  = in_first;
         r_cnt_next   = 5'd0;
         r_limit_next = w_new_limit;
         r_ena_next   = 1'b1;
         r_v_next     = in_first[WIDTH-1:0];
         r_last_next  = (w_new_limit == 5'd1);
      end else if (w_xfer && !r_last) begin
         r_cnt_next   = w_cnt_inc;
         r_v_next     = w_words[w_cnt_inc];
         r_last_next  = (w_cnt_inc == r_limit - 5'd1);
      end else if (w_xfer) begin
         // Item finished with nothing queued: word value is left as-is.
         r_ena_next   = 1'b0;
         r_last_next  = 1'b0;
      end
   end

endmodule

// File: tb/tb_echo_serializer.sv
// Scoreboard bench for echo_serializer: an upstream item queue feeds the DUT and the
// expected word stream is queued at each dequeue and popped on each output transfer.
module tb_echo_serializer;

   logic          CLK = 1'b0;
   logic          RST;
   logic [703:0]  first;
   logic          first_rdy;
   logic          deq_rdy;
   logic          deq_ena;
   logic          enq_ena;
   logic [31:0]   enq_v;
   logic          enq_last;
   logic          enq_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [703:0]  up_q[$];
   logic [32:0]   sb_q[$];

   int n_xfer, n_deq, first_deq_cyc, last_xfer_cyc;
   bit deq2_on_last;

   always #5 CLK = ~CLK;

   echo_serializer #(.WIDTH(32), .DATA_WORDS(20)) dut (
      .CLK(CLK),
      .RST(RST),
      .in_first(first),
      .in_first_rdy(first_rdy),
      .in_deq_rdy(deq_rdy),
      .in_deq_ena(deq_ena),
      .out_enq_ena(enq_ena),
      .out_enq_v(enq_v),
      .out_enq_last(enq_last),
      .out_enq_rdy(enq_rdy)
   );

   function automatic logic [703:0] make_item(input logic [31:0] tag, input logic [31:0] n,
                                              input logic [31:0] base);
      logic [703:0] it;
      it = '0;
      it[31:0]  = tag;
      it[63:32] = n;
      for (int k = 0; k < 20; k++) it[(k+2)*32 +: 32] = base * (k + 1);
      return it;
   endfunction

   task automatic push_expected(input logic [703:0] it);
      int len;
      len = (it[63:32] >= 32'd20) ? 22 : int'(it[63:32]) + 2;
      for (int k = 0; k < len; k++) sb_q.push_back({(k == len - 1), it[k*32 +: 32]});
   endtask

   // Drives the upstream queue and downstream ready; compares every transferred word.
   task automatic run_stream(input int max_cyc, input int stall_pct, input int stop_after);
      int cyc;
      bit prev_stall, xfer;
      logic [31:0] prev_v, exp_v;
      logic prev_last, exp_last;
      logic [32:0] e;
      cyc = 0; prev_stall = 0; prev_v = '0; prev_last = 0;
      n_xfer = 0; n_deq = 0; first_deq_cyc = -1; last_xfer_cyc = -1; deq2_on_last = 0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (prev_stall) begin
            n_tests++;
            if (enq_ena !== 1'b1 || enq_v !== prev_v || enq_last !== prev_last) begin
               n_fail++;
               $display("FAIL stall_hold: got ena=%b v=%h last=%b want ena=1 v=%h last=%b",
                        enq_ena, enq_v, enq_last, prev_v, prev_last);
            end
         end
         enq_rdy = ($urandom_range(99) >= stall_pct);
         if (up_q.size() > 0) begin first = up_q[0]; first_rdy = 1'b1; end
         else first_rdy = 1'b0;
         #1;
         xfer = enq_ena && enq_rdy;
         if (xfer) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_word: got v=%h last=%b want no word", enq_v, enq_last);
            end else begin
               e = sb_q.pop_front();
               exp_v = e[31:0]; exp_last = e[32];
               if (enq_v !== exp_v || enq_last !== exp_last) begin
                  n_fail++;
                  $display("FAIL word: got v=%h last=%b want v=%h last=%b",
                           enq_v, enq_last, exp_v, exp_last);
               end
            end
            n_xfer++;
            last_xfer_cyc = cyc;
         end
         if (deq_ena) begin
            n_tests++;
            if (!(first_rdy && deq_rdy)) begin
               n_fail++;
               $display("FAIL deq_gate: got deq_ena=1 with first_rdy=%b deq_rdy=%b want 0",
                        first_rdy, deq_rdy);
            end
            if (up_q.size() > 0) begin
               push_expected(up_q[0]);
               void'(up_q.pop_front());
            end
            n_deq++;
            if (first_deq_cyc < 0) first_deq_cyc = cyc;
            if (n_deq == 2) deq2_on_last = xfer && enq_last;
         end
         prev_stall = enq_ena && !enq_rdy;
         prev_v = enq_v; prev_last = enq_last;
         if (stop_after > 0 && n_xfer >= stop_after) break;
         if (up_q.size() == 0 && sb_q.size() == 0) break;
         if (cyc >= max_cyc) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: got %0d words left want 0", sb_q.size());
            up_q.delete(); sb_q.delete();
            break;
         end
      end
      first_rdy = 1'b0;
      enq_rdy = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1; first = make_item(32'h1, 32'd1, 32'h5); first_rdy = 1'b1;
      deq_rdy = 1'b1; enq_rdy = 1'b1;
      repeat (2) begin
         @(negedge CLK); #1;
         n_tests++;
         if (deq_ena !== 1'b0 || enq_ena !== 1'b0 || enq_v !== 32'h0 || enq_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got deq=%b ena=%b v=%h last=%b want all 0",
                     deq_ena, enq_ena, enq_v, enq_last);
         end
      end
      first_rdy = 1'b0;
      RST = 1'b0;
   endtask

   task automatic test_single();
      up_q.push_back(make_item(32'hA5A5A5A5, 32'd3, 32'h11));
      run_stream(100, 0, 0);
      n_tests++;
      if (n_xfer != 5 || n_deq != 1 || last_xfer_cyc - first_deq_cyc != 5) begin
         n_fail++;
         $display("FAIL single_timing: got words=%0d deqs=%0d span=%0d want 5 1 5",
                  n_xfer, n_deq, last_xfer_cyc - first_deq_cyc);
      end
      @(negedge CLK); #1;
      n_tests++;
      if (enq_ena !== 1'b0 || enq_last !== 1'b0 || enq_v !== 32'h33) begin
         n_fail++;
         $display("FAIL single_idle: got ena=%b last=%b v=%h want 0 0 00000033",
                  enq_ena, enq_last, enq_v);
      end
   endtask

   task automatic test_lengths();
      up_q.push_back(make_item(32'hC0DE0000, 32'd0, 32'h100));
      run_stream(100, 0, 0);
      n_tests++;
      if (n_xfer != 2) begin
         n_fail++;
         $display("FAIL len_zero: got %0d words want 2", n_xfer);
      end
      up_q.push_back(make_item(32'hC0DE0001, 32'hFFFFFFFF, 32'h200));
      run_stream(100, 0, 0);
      n_tests++;
      if (n_xfer != 22) begin
         n_fail++;
         $display("FAIL len_max: got %0d words want 22", n_xfer);
      end
      up_q.push_back(make_item(32'hC0DE0002, 32'd19, 32'h300));
      run_stream(100, 0, 0);
      n_tests++;
      if (n_xfer != 21) begin
         n_fail++;
         $display("FAIL len_19: got %0d words want 21", n_xfer);
      end
   endtask

   task automatic test_back_to_back();
      up_q.push_back(make_item(32'hB0000001, 32'd1, 32'h7));
      up_q.push_back(make_item(32'hB0000002, 32'd2, 32'h9));
      run_stream(100, 0, 0);
      n_tests++;
      if (n_xfer != 7 || n_deq != 2 || last_xfer_cyc - first_deq_cyc != 7 || !deq2_on_last) begin
         n_fail++;
         $display("FAIL back_to_back: got words=%0d deqs=%0d span=%0d deq2_on_last=%0b want 7 2 7 1",
                  n_xfer, n_deq, last_xfer_cyc - first_deq_cyc, deq2_on_last);
      end
   endtask

   task automatic test_stall();
      up_q.push_back(make_item(32'h57A11000, 32'd20, 32'h1234));
      run_stream(2000, 50, 0);
      n_tests++;
      if (n_xfer != 22 || n_deq != 1) begin
         n_fail++;
         $display("FAIL stall_count: got words=%0d deqs=%0d want 22 1", n_xfer, n_deq);
      end
   endtask

   task automatic test_no_deq();
      deq_rdy = 1'b0; first = make_item(32'hDEAD0000, 32'd4, 32'h3); first_rdy = 1'b1;
      repeat (4) begin
         @(negedge CLK); #1;
         n_tests++;
         if (deq_ena !== 1'b0 || enq_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL no_deq: got deq=%b ena=%b want 0 0", deq_ena, enq_ena);
         end
      end
      first_rdy = 1'b0; deq_rdy = 1'b1;
   endtask

   task automatic test_reset_mid();
      up_q.push_back(make_item(32'hAB000010, 32'd10, 32'h21));
      run_stream(100, 0, 3);
      @(negedge CLK);
      RST = 1'b1; first = make_item(32'hAB000011, 32'd2, 32'h44); first_rdy = 1'b1;
      #1;
      n_tests++;
      if (deq_ena !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_deq: got deq=%b want 0", deq_ena);
      end
      @(negedge CLK);
      RST = 1'b0; first_rdy = 1'b0;
      #1;
      n_tests++;
      if (enq_ena !== 1'b0 || enq_v !== 32'h0 || enq_last !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_out: got ena=%b v=%h last=%b want 0 0 0",
                  enq_ena, enq_v, enq_last);
      end
      sb_q.delete();
      up_q.push_back(make_item(32'hAB000012, 32'd2, 32'h44));
      run_stream(100, 0, 0);
      n_tests++;
      if (n_xfer != 4) begin
         n_fail++;
         $display("FAIL reset_mid_next: got %0d words want 4", n_xfer);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_lengths();
      test_back_to_back();
      test_stall();
      test_no_deq();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
